// File: rtl/risc_pkg.sv
// Shared encodings for the multicycle RISC control unit: opcodes, field
// positions, ALU/branch codes, FSM states and the decoded-instruction bundle.
package risc_pkg;

   localparam int unsigned OPC_HI   = 31;
   localparam int unsigned OPC_LO   = 26;
   localparam int unsigned CLS_HI   = 31;
   localparam int unsigned CLS_LO   = 30;
   localparam int unsigned FUNCT_HI = 3;
   localparam int unsigned FUNCT_LO = 0;

   localparam logic [5:0] OP_LW   = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100001;
   localparam logic [5:0] OP_BEQZ = 6'b110000;
   localparam logic [5:0] OP_BNEZ = 6'b110001;
   localparam logic [5:0] OP_BLTZ = 6'b110010;
   localparam logic [5:0] OP_J    = 6'b110011;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLA = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;

   typedef enum logic [1:0] {
      CLS_RTYPE  = 2'b00,
      CLS_ALUIMM = 2'b01,
      CLS_MEM    = 2'b10,
      CLS_CTRL   = 2'b11
   } cls_e;

   typedef enum logic [1:0] {
      COND_NEVER = 2'b00,
      COND_EQZ   = 2'b01,
      COND_NEZ   = 2'b10,
      COND_LTZ   = 2'b11
   } opcond_e;

   typedef enum logic [2:0] {
      S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
   } state_e;

   typedef struct packed {
      cls_e       cls;
      logic       is_lw;
      logic       is_sw;
      logic       is_br;
      logic       is_j;
      logic       is_halt;
      logic       is_illegal;
      logic [3:0] alufunc;
      opcond_e    opcond;
   } decode_t;

   typedef struct packed {
      logic       readim;
      logic       ldir;
      logic       ldnpc;
      logic       ldimm;
      logic       ldA;
      logic       ldB;
      logic       alusel1;
      logic       alusel2;
      logic       aluen;
      logic       ldaluout;
      logic [3:0] alufunc;
      opcond_e    opcond;
      logic       seldest;
      logic       regwrite;
      logic       selwb;
      logic       writedmem;
      logic       readdmem;
      logic       ldlmd;
      logic       branch;
      logic       ldpc;
   } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: classifies the IR contents and derives
// the ALU function and branch condition for the control FSM.
module control_decode
   import risc_pkg::*;
(
   input  logic [31:0] irout_i,
   output decode_t     dec_o
);

   logic [5:0] opcode;
   logic       unused_fields;

   assign opcode        = irout_i[OPC_HI:OPC_LO];
   assign unused_fields = ^irout_i[OPC_LO-1:FUNCT_HI+1];

   always_comb begin
      dec_o     = '0;
      dec_o.cls = cls_e'(irout_i[CLS_HI:CLS_LO]);
      case (irout_i[CLS_HI:CLS_LO])
         2'b00: dec_o.alufunc = irout_i[FUNCT_HI:FUNCT_LO];
         2'b01: dec_o.alufunc = opcode[3:0];
         2'b10: begin
            dec_o.alufunc    = ALU_ADD;
            dec_o.is_lw      = (opcode == OP_LW);
            dec_o.is_sw      = (opcode == OP_SW);
            dec_o.is_illegal = !((opcode == OP_LW) || (opcode == OP_SW));
         end
         default: begin
            dec_o.alufunc = ALU_ADD;
            dec_o.is_j    = (opcode == OP_J);
            dec_o.is_halt = (opcode == OP_HALT);
            case (opcode)
               OP_BEQZ: dec_o.opcond = COND_EQZ;
               OP_BNEZ: dec_o.opcond = COND_NEZ;
               OP_BLTZ: dec_o.opcond = COND_LTZ;
               default: dec_o.opcond = COND_NEVER;
            endcase
            dec_o.is_br      = (opcode == OP_BEQZ) || (opcode == OP_BNEZ) ||
                               (opcode == OP_BLTZ);
            dec_o.is_illegal = !(dec_o.is_br || dec_o.is_j || dec_o.is_halt);
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the RISC datapath: sequences IF/ID/EX/MEM/WB,
// drives registered datapath strobes and counts retired instructions.
module control_unit
   import risc_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      irout,
   output logic             readim,
   output logic             ldir,
   output logic             ldnpc,
   output logic             ldimm,
   output logic             ldA,
   output logic             ldB,
   output logic             alusel1,
   output logic             alusel2,
   output logic             aluen,
   output logic             ldaluout,
   output logic [3:0]       alufunc,
   output logic [1:0]       opcond,
   output logic             seldest,
   output logic             regwrite,
   output logic             selwb,
   output logic             writedmem,
   output logic             readdmem,
   output logic             ldlmd,
   output logic             branch,
   output logic             ldpc,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   decode_t          dec;
   state_e           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             busy_q, halted_q, illegal_q;
   logic [CNT_W-1:0] retired_q;

   control_decode u_decode (
      .irout_i (irout),
      .dec_o   (dec)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_IF;
         S_IF:    state_d = S_ID;
         S_ID:    state_d = (dec.is_halt || dec.is_illegal) ? S_HALT : S_EX;
         S_EX:    state_d = dec.is_j ? S_IF :
                            (dec.is_lw || dec.is_sw || dec.is_br) ? S_MEM : S_WB;
         S_MEM:   state_d = dec.is_lw ? S_WB : S_IF;
         S_WB:    state_d = S_IF;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are decoded for the state being entered so they appear registered;
   // the IR is already stable whenever the target state depends on it.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_IF: begin
            ctrl_d.readim = 1'b1;
            ctrl_d.ldir   = 1'b1;
            ctrl_d.ldnpc  = 1'b1;
            ctrl_d.ldimm  = 1'b1;
         end
         S_ID: begin
            ctrl_d.ldA = 1'b1;
            ctrl_d.ldB = 1'b1;
         end
         S_EX: begin
            if (dec.is_j) begin
               ctrl_d.branch = 1'b1;
               ctrl_d.ldpc   = 1'b1;
            end else begin
               ctrl_d.aluen    = 1'b1;
               ctrl_d.ldaluout = 1'b1;
               ctrl_d.alusel1  = !dec.is_br;
               ctrl_d.alusel2  = (dec.cls != CLS_RTYPE);
               ctrl_d.alufunc  = dec.alufunc;
            end
         end
         S_MEM: begin
            if (dec.is_lw) begin
               ctrl_d.readdmem = 1'b1;
               ctrl_d.ldlmd    = 1'b1;
            end else if (dec.is_sw) begin
               ctrl_d.writedmem = 1'b1;
               ctrl_d.ldpc      = 1'b1;
            end else begin
               ctrl_d.ldpc   = 1'b1;
               ctrl_d.opcond = dec.opcond;
            end
         end
         S_WB: begin
            ctrl_d.regwrite = 1'b1;
            ctrl_d.ldpc     = 1'b1;
            ctrl_d.selwb    = !dec.is_lw;
            ctrl_d.seldest  = (dec.cls != CLS_RTYPE);
         end
         default: ctrl_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         busy_q  <= state_d inside {S_IF, S_ID, S_EX, S_MEM, S_WB};
         if (state_q == S_ID && dec.is_halt)    halted_q  <= 1'b1;
         if (state_q == S_ID && dec.is_illegal) illegal_q <= 1'b1;
         if (ctrl_q.ldpc) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign readim    = ctrl_q.readim;
   assign ldir      = ctrl_q.ldir;
   assign ldnpc     = ctrl_q.ldnpc;
   assign ldimm     = ctrl_q.ldimm;
   assign ldA       = ctrl_q.ldA;
   assign ldB       = ctrl_q.ldB;
   assign alusel1   = ctrl_q.alusel1;
   assign alusel2   = ctrl_q.alusel2;
   assign aluen     = ctrl_q.aluen;
   assign ldaluout  = ctrl_q.ldaluout;
   assign alufunc   = ctrl_q.alufunc;
   assign opcond    = ctrl_q.opcond;
   assign seldest   = ctrl_q.seldest;
   assign regwrite  = ctrl_q.regwrite;
   assign selwb     = ctrl_q.selwb;
   assign writedmem = ctrl_q.writedmem;
   assign readdmem  = ctrl_q.readdmem;
   assign ldlmd     = ctrl_q.ldlmd;
   assign branch    = ctrl_q.branch;
   assign ldpc      = ctrl_q.ldpc;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: random instruction stream compared
// cycle by cycle against a per-class phase model, plus reset/halt/illegal cases.
module tb_control_unit;

   localparam int unsigned CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      irout = '0;
   logic             readim, ldir, ldnpc, ldimm, ldA, ldB;
   logic             alusel1, alusel2, aluen, ldaluout;
   logic [3:0]       alufunc;
   logic [1:0]       opcond;
   logic             seldest, regwrite, selwb, writedmem, readdmem, ldlmd;
   logic             branch, ldpc, busy, halted, illegal;
   logic [CNT_W-1:0] retired;

   typedef struct packed {
      logic readim, ldir, ldnpc, ldimm, ldA, ldB;
      logic alusel1, alusel2, aluen, ldaluout;
      logic [3:0] alufunc;
      logic [1:0] opcond;
      logic seldest, regwrite, selwb, writedmem, readdmem, ldlmd;
      logic branch, ldpc, busy, halted, illegal;
   } cw_t;

   cw_t              obs;
   int unsigned      n_vec = 0;
   int unsigned      n_bad = 0;
   logic [CNT_W-1:0] model_ret = '0;

   control_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .irout(irout),
      .readim(readim), .ldir(ldir), .ldnpc(ldnpc), .ldimm(ldimm),
      .ldA(ldA), .ldB(ldB), .alusel1(alusel1), .alusel2(alusel2),
      .aluen(aluen), .ldaluout(ldaluout), .alufunc(alufunc), .opcond(opcond),
      .seldest(seldest), .regwrite(regwrite), .selwb(selwb),
      .writedmem(writedmem), .readdmem(readdmem), .ldlmd(ldlmd),
      .branch(branch), .ldpc(ldpc), .busy(busy), .halted(halted),
      .illegal(illegal), .retired(retired)
   );

   assign obs = {readim, ldir, ldnpc, ldimm, ldA, ldB, alusel1, alusel2, aluen,
                 ldaluout, alufunc, opcond, seldest, regwrite, selwb, writedmem,
                 readdmem, ldlmd, branch, ldpc, busy, halted, illegal};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_bad(input logic [5:0] o);
      if (o[5:4] == 2'b10) return (o[3:1] != 3'b000);
      if (o[5:4] == 2'b11)
         return !(o inside {6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b111111});
      return 1'b0;
   endfunction

   function automatic int unsigned lat(input logic [31:0] ins);
      logic [5:0] o = ins[31:26];
      if (o == 6'b111111 || is_bad(o)) return 2;
      if (o == 6'b110011) return 3;
      if (o == 6'b100000) return 5;
      return 4;
   endfunction

   // Expected control word in cycle k (0 = fetch) of instruction ins.
   function automatic cw_t expw(input logic [31:0] ins, input int unsigned k);
      cw_t         w = '0;
      logic [5:0]  o = ins[31:26];
      int unsigned last = lat(ins) - 1;
      w.busy = 1'b1;
      if (k == 0) begin
         w.readim = 1'b1; w.ldir = 1'b1; w.ldnpc = 1'b1; w.ldimm = 1'b1;
      end else if (k == 1) begin
         w.ldA = 1'b1; w.ldB = 1'b1;
      end else if (o == 6'b110011) begin
         w.branch = 1'b1; w.ldpc = 1'b1;
      end else if (k == 2) begin
         w.aluen    = 1'b1;
         w.ldaluout = 1'b1;
         w.alusel1  = (o[5:4] != 2'b11);
         w.alusel2  = (o[5:4] != 2'b00);
         w.alufunc  = o[5] ? 4'h0 : (o[4] ? o[3:0] : ins[3:0]);
      end else begin
         if (k == last) w.ldpc = 1'b1;
         case (o[5:4])
            2'b11: w.opcond = o[1:0] + 2'd1;
            2'b10: begin
               if (o[0]) w.writedmem = 1'b1;
               else if (k == 3) begin w.readdmem = 1'b1; w.ldlmd = 1'b1; end
               else begin w.regwrite = 1'b1; w.seldest = 1'b1; end
            end
            default: begin
               w.regwrite = 1'b1; w.selwb = 1'b1; w.seldest = o[4];
            end
         endcase
      end
      return w;
   endfunction

   function automatic logic [31:0] mk_rand();
      logic [31:0] r = $urandom;
      case ($urandom_range(0, 5))
         0: r[31:26] = 6'b000000;
         1: r[31:30] = 2'b01;
         2: r[31:26] = 6'b100000;
         3: r[31:26] = 6'b100001;
         4: r[31:26] = {4'b1100, 2'($urandom_range(0, 2))};
         default: r[31:26] = 6'b110011;
      endcase
      return r;
   endfunction

   // Called with the FSM about to enter (or in) IF; abort_at >= 0 asserts reset there.
   task automatic run_instr(input logic [31:0] ins, input int abort_at);
      int unsigned n = lat(ins);
      for (int unsigned k = 0; k < n; k++) begin
         @(negedge clk);
         check($sformatf("cw_op%02h_k%0d", ins[31:26], k), 64'(obs), 64'(expw(ins, k)));
         if (k == 0) begin
            check("retired", 64'(retired), 64'(model_ret));
            irout = ins;
            start = 1'b0;
         end
         if (int'(k) == abort_at) begin
            reset = 1'b0;
            #1;
            check("rst_async", 64'(obs), 64'(0));
            return;
         end
      end
      if (n > 2) model_ret++;
   endtask

   initial begin
      cw_t hw;
      @(negedge clk);
      check("reset_cw", 64'(obs), 64'(0));
      check("reset_ret", 64'(retired), 64'(0));
      reset = 1'b1;
      @(negedge clk);
      check("idle_cw", 64'(obs), 64'(0));

      start = 1'b1;
      run_instr(32'h0022_1800, -1);
      run_instr(32'h8023_0004, -1);
      run_instr(32'h8423_0008, -1);
      run_instr(32'hC400_0010, -1);
      run_instr(32'hCC00_0040, -1);
      for (int i = 0; i < 60; i++) run_instr(mk_rand(), -1);

      run_instr(32'h5C41_0007, 2);
      model_ret = '0;
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_cw", 64'(obs), 64'(0));
      end
      reset = 1'b1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_cw", 64'(obs), 64'(0));
         check("post_rst_ret", 64'(retired), 64'(0));
      end

      force dut.retired_q = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      release dut.retired_q;
      @(negedge clk);
      check("ret_preload", 64'(retired), 64'(32'hFFFF_FFFF));
      model_ret = '1;
      start = 1'b1;
      run_instr(32'h0000_0001, -1);

      run_instr(32'hFC00_0000, -1);
      hw = '0;
      hw.halted = 1'b1;
      repeat (20) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("halt_cw", 64'(obs), 64'(hw));
         check("halt_ret", 64'(retired), 64'(model_ret));
      end

      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("halt_rst_cw", 64'(obs), 64'(0));
      reset = 1'b1;
      model_ret = '0;
      start = 1'b1;
      run_instr(32'h4400_1234, -1);
      run_instr(32'hA800_0000, -1);
      hw = '0;
      hw.illegal = 1'b1;
      repeat (5) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("illegal_cw", 64'(obs), 64'(hw));
         check("illegal_ret", 64'(retired), 64'(model_ret));
      end
      reset = 1'b0;
      @(negedge clk);
      check("illegal_clr", 64'(obs), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
